// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
// Shared definitions for the reset sequencer slice: the 2-bit sequencer
// state type with its encodings, and the width of the soft-reset counter.
package rst_seq_pkg;

  localparam int unsigned SOFT_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain
// Async-assert / sync-deassert reset synchroniser, SYNC_STAGES flops deep.
// Ports:
//   clk        in  1  clock
//   rst_n      in  1  raw asynchronous active-low reset
//   sync_rstn  out 1  synchronised reset (last stage); high SYNC_STAGES
//                     edges after rst_n rises, low immediately when rst_n falls
module rst_sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_rstn
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_rstn = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer
// Synchronises system reset deassertion, then releases NUM_DOMAINS
// active-low domain resets one by one, STAGGER_CYC cycles apart, starting
// with bit 0. With RST_SEQ_SOFT_EN defined, a soft-reset request sampled in
// ST_DONE re-asserts all domains for HOLD_CYC cycles and re-runs the release
// sequence; accepted requests are counted (saturating).
// Ports:
//   sys_clk       in  1            clock
//   sys_resetn    in  1            async active-low hard reset
//   domain_rstn   out NUM_DOMAINS  per-domain resets (registered)
//   seq_done      out 1            all domains released (registered)
//   seq_state     out 2            current sequencer state
//   soft_rst_req  in  1            soft reset request   (RST_SEQ_SOFT_EN only)
//   soft_cnt      out SOFT_CNT_W   accepted soft resets (RST_SEQ_SOFT_EN only)
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned STAGGER_CYC = 4,
  parameter int unsigned HOLD_CYC    = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_resetn,
  output logic [NUM_DOMAINS-1:0] domain_rstn,
  output logic                   seq_done,
  output logic [1:0]             seq_state
`ifdef RST_SEQ_SOFT_EN
  ,
  input  logic                   soft_rst_req,
  output logic [SOFT_CNT_W-1:0]  soft_cnt
`endif
);

  localparam int unsigned MAX_CYC = (STAGGER_CYC > HOLD_CYC) ? STAGGER_CYC : HOLD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic                   sync_rstn;

  state_t                 state_q,  state_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic [IDX_W-1:0]       idx_q,    idx_d;
  logic [NUM_DOMAINS-1:0] domain_q, domain_d;
  logic                   done_q,   done_d;
`ifdef RST_SEQ_SOFT_EN
  logic [SOFT_CNT_W-1:0]  soft_cnt_q, soft_cnt_d;
`endif

  rst_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (sys_clk),
    .rst_n     (sys_resetn),
    .sync_rstn (sync_rstn)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    domain_d = domain_q;
    done_d   = done_q;
`ifdef RST_SEQ_SOFT_EN
    soft_cnt_d = soft_cnt_q;
`endif
    case (state_q)
      ST_RESET: begin
        if (sync_rstn) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER_CYC - 1)) begin
          cnt_d = '0;
          // Decoded loop rather than domain_d[idx_q] keeps the select in range
          // for every NUM_DOMAINS, including 1.
          for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            if (idx_q == IDX_W'(k)) domain_d[k] = 1'b1;
          end
          if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
`ifdef RST_SEQ_SOFT_EN
        if (soft_rst_req) begin
          state_d  = ST_HOLD;
          domain_d = '0;
          done_d   = 1'b0;
          cnt_d    = '0;
          if (soft_cnt_q != '1) soft_cnt_d = soft_cnt_q + SOFT_CNT_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      idx_q    <= '0;
      domain_q <= '0;
      done_q   <= 1'b0;
`ifdef RST_SEQ_SOFT_EN
      soft_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      domain_q <= domain_d;
      done_q   <= done_d;
`ifdef RST_SEQ_SOFT_EN
      soft_cnt_q <= soft_cnt_d;
`endif
    end
  end

  assign domain_rstn = domain_q;
  assign seq_done    = done_q;
  assign seq_state   = state_q;
`ifdef RST_SEQ_SOFT_EN
  assign soft_cnt    = soft_cnt_q;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer
// Directed bench for rst_sequencer: default-parameter instance plus a
// corner instance (SYNC_STAGES=3, NUM_DOMAINS=1, STAGGER_CYC=1) sharing
// clock and reset. Soft-reset steps are built only with RST_SEQ_SOFT_EN.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  logic       sys_clk = 1'b0;
  logic       sys_resetn;
  logic       soft_rst_req;
  logic [2:0] domain_rstn;
  logic       seq_done;
  logic [1:0] seq_state;
  logic [0:0] c_domain_rstn;
  logic       c_seq_done;
  logic [1:0] c_seq_state;
`ifdef RST_SEQ_SOFT_EN
  logic [7:0] soft_cnt;
  logic [7:0] c_soft_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic seen3;

  always #5 sys_clk = ~sys_clk;

  rst_sequencer #(
    .SYNC_STAGES (2),
    .NUM_DOMAINS (3),
    .STAGGER_CYC (4),
    .HOLD_CYC    (8)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_resetn   (sys_resetn),
    .domain_rstn  (domain_rstn),
    .seq_done     (seq_done),
    .seq_state    (seq_state)
`ifdef RST_SEQ_SOFT_EN
    ,
    .soft_rst_req (soft_rst_req),
    .soft_cnt     (soft_cnt)
`endif
  );

  rst_sequencer #(
    .SYNC_STAGES (3),
    .NUM_DOMAINS (1),
    .STAGGER_CYC (1),
    .HOLD_CYC    (8)
  ) dut_corner (
    .sys_clk      (sys_clk),
    .sys_resetn   (sys_resetn),
    .domain_rstn  (c_domain_rstn),
    .seq_done     (c_seq_done),
    .seq_state    (c_seq_state)
`ifdef RST_SEQ_SOFT_EN
    ,
    .soft_rst_req (1'b0),
    .soft_cnt     (c_soft_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 time unit later.
  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Call right after raising sys_resetn (between edges); checks edges 1..16.
  task automatic check_release(input string ph);
    logic [2:0] exp_dom;
    logic [1:0] exp_st;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      exp_dom = {e >= 15, e >= 11, e >= 7};
      exp_st  = (e <= 2) ? 2'd0 : (e <= 14) ? 2'd1 : 2'd2;
      chk($sformatf("%s_dom_e%0d", ph, e), domain_rstn, exp_dom);
      chk($sformatf("%s_state_e%0d", ph, e), seq_state, exp_st);
      chk($sformatf("%s_done_e%0d", ph, e), seq_done, e >= 15);
      chk($sformatf("%s_cdom_e%0d", ph, e), c_domain_rstn, e >= 5);
      chk($sformatf("%s_cdone_e%0d", ph, e), c_seq_done, e >= 5);
    end
  endtask

  initial begin
    sys_resetn   = 1'b0;
    soft_rst_req = 1'b0;

    // Power-on reset held for 10 cycles
    step(10);
    chk("por_dom", domain_rstn, 3'b000);
    chk("por_done", seq_done, 1'b0);
    chk("por_state", seq_state, 2'd0);
    chk("por_cdom", c_domain_rstn, 1'b0);
`ifdef RST_SEQ_SOFT_EN
    chk("por_softcnt", soft_cnt, 8'd0);
`endif
    sys_resetn = 1'b1;
    check_release("por");

    // Mid-sequence hard reset between edges 9 and 10
    sys_resetn = 1'b0;
    step(3);
    sys_resetn = 1'b1;
    step(9);
    chk("mid_pre_dom", domain_rstn, 3'b001);
    chk("mid_pre_state", seq_state, 2'd1);
    #3;
    sys_resetn = 1'b0;
    #1;
    chk("mid_async_dom", domain_rstn, 3'b000);
    chk("mid_async_state", seq_state, 2'd0);
    chk("mid_async_done", seq_done, 1'b0);
    chk("mid_async_cdom", c_domain_rstn, 1'b0);
    step(4);
    sys_resetn = 1'b1;
    check_release("rerel");

    // No request: state must never read 3
    seen3 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (seq_state == 2'd3) seen3 = 1'b1;
    end
    chk("never_hold", seen3, 1'b0);
    chk("idle_dom", domain_rstn, 3'b111);

`ifdef RST_SEQ_SOFT_EN
    // Single-cycle soft request accepted at edge N
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    chk("soft_n_dom", domain_rstn, 3'b000);
    chk("soft_n_state", seq_state, 2'd3);
    chk("soft_n_done", seq_done, 1'b0);
    chk("soft_n_cnt", soft_cnt, 8'd1);
    for (int j = 1; j <= 20; j++) begin
      logic [2:0] exp_dom;
      logic [1:0] exp_st;
      step(1);
      exp_dom = {j >= 20, j >= 16, j >= 12};
      exp_st  = (j < 8) ? 2'd3 : (j < 20) ? 2'd1 : 2'd2;
      chk($sformatf("soft_dom_n%0d", j), domain_rstn, exp_dom);
      chk($sformatf("soft_state_n%0d", j), seq_state, exp_st);
      chk($sformatf("soft_done_n%0d", j), seq_done, j >= 20);
    end

    // Request held through HOLD and RELEASE: only the first edge counts
    soft_rst_req = 1'b1;
    step(1);
    chk("ign_accept_cnt", soft_cnt, 8'd2);
    step(9);
    chk("ign_rel_state", seq_state, 2'd1);
    chk("ign_rel_cnt", soft_cnt, 8'd2);
    step(10);
    chk("ign_late_cnt", soft_cnt, 8'd2);
    soft_rst_req = 1'b0;
    step(1);
    chk("ign_done_state", seq_state, 2'd2);
    chk("ign_done_dom", domain_rstn, 3'b111);
    chk("ign_done_cnt", soft_cnt, 8'd2);

    // Held continuously: one accept every 21 edges, saturating at 255
    soft_rst_req = 1'b1;
    step(5292);
    chk("sat_254", soft_cnt, 8'd254);
    step(1);
    chk("sat_255", soft_cnt, 8'd255);
    chk("sat_state", seq_state, 2'd3);
    step(200);
    chk("sat_stick", soft_cnt, 8'd255);
    soft_rst_req = 1'b0;
`endif

    // Async clear mid-cycle
    sys_resetn = 1'b0;
    #1;
    chk("end_dom", domain_rstn, 3'b000);
    chk("end_state", seq_state, 2'd0);
    chk("end_done", seq_done, 1'b0);
`ifdef RST_SEQ_SOFT_EN
    chk("end_softcnt", soft_cnt, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
